// File: rtl/ads131_pkg.sv
// Shared types and constants for the ADS131 frame receiver.
package ads131_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StReq,
        StWait,
        StDone
    } state_t;

    localparam int unsigned N_CH_DEFAULT   = 8;
    localparam int unsigned BYTES_PER_WORD = 3;
    localparam logic [3:0]  STATUS_SYNC    = 4'hC;

    // One status word followed by one word per channel.
    function automatic int unsigned frame_bytes(input int unsigned n_ch);
        return BYTES_PER_WORD * (n_ch + 1);
    endfunction

endpackage

// File: rtl/ads131_drdy_sync.sv
// DRDY double-flop synchronizer with a one-cycle falling-edge strobe.
module ads131_drdy_sync (
    input  logic I_clk_50M,
    input  logic I_rst_n,
    input  logic I_drdy_n,
    output logic O_drdy_fall
);

    logic drdy_meta_q;
    logic drdy_sync_q;
    logic drdy_prev_q;

    // Flops reset high so a low DRDY during reset is not seen as an edge.
    always_ff @(posedge I_clk_50M or negedge I_rst_n) begin
        if (!I_rst_n) begin
            drdy_meta_q <= 1'b1;
            drdy_sync_q <= 1'b1;
            drdy_prev_q <= 1'b1;
        end else begin
            drdy_meta_q <= I_drdy_n;
            drdy_sync_q <= drdy_meta_q;
            drdy_prev_q <= drdy_sync_q;
        end
    end

    assign O_drdy_fall = drdy_prev_q & ~drdy_sync_q;

endmodule

// File: rtl/ads131_frame_rx.sv
// Reads one status word plus N_CH 24-bit channel words from the SPI byte engine per DRDY.
module ads131_frame_rx
    import ads131_pkg::*;
#(
    parameter int unsigned N_CH       = N_CH_DEFAULT,
    parameter int unsigned RX_TIMEOUT = 1023
) (
    input  logic        I_clk_50M,
    input  logic        I_rst_n,
    input  logic        I_enable,
    input  logic        I_drdy_n,
    output logic        O_spi_en,
    output logic        O_rx_en,
    input  logic        I_rx_done,
    input  logic [7:0]  I_rx_data,
    output logic [23:0] O_status,
    output logic        O_status_valid,
    output logic [23:0] O_ch_data,
    output logic [2:0]  O_ch_idx,
    output logic        O_ch_valid,
    output logic        O_frame_done,
    output logic        O_sync_err,
    output logic        O_timeout,
    output logic        O_overrun,
    input  logic        I_clr_ovr
);

    localparam int unsigned FRAME_BYTES = frame_bytes(N_CH);
    localparam int unsigned CNT_W       = $clog2(FRAME_BYTES);
    localparam int unsigned IDX_W       = $clog2(N_CH + 1);
    localparam int unsigned WAIT_W      = $clog2(RX_TIMEOUT + 1);

    state_t              state_q;
    logic [CNT_W-1:0]    byte_cnt_q;
    logic [1:0]          byte_pos_q;
    logic [IDX_W-1:0]    word_idx_q;
    logic [15:0]         word_sr_q;
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic                drdy_fall;

    ads131_drdy_sync u_drdy_sync (
        .I_clk_50M   (I_clk_50M),
        .I_rst_n     (I_rst_n),
        .I_drdy_n    (I_drdy_n),
        .O_drdy_fall (drdy_fall)
    );

    always_ff @(posedge I_clk_50M or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q        <= StIdle;
            byte_cnt_q     <= '0;
            byte_pos_q     <= '0;
            word_idx_q     <= '0;
            word_sr_q      <= '0;
            wait_cnt_q     <= '0;
            O_spi_en       <= 1'b0;
            O_rx_en        <= 1'b0;
            O_status       <= '0;
            O_status_valid <= 1'b0;
            O_ch_data      <= '0;
            O_ch_idx       <= '0;
            O_ch_valid     <= 1'b0;
            O_frame_done   <= 1'b0;
            O_sync_err     <= 1'b0;
            O_timeout      <= 1'b0;
        end else begin
            O_rx_en        <= 1'b0;
            O_status_valid <= 1'b0;
            O_ch_valid     <= 1'b0;
            O_frame_done   <= 1'b0;
            O_sync_err     <= 1'b0;
            O_timeout      <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (I_enable) begin
                        state_q    <= StArm;
                        O_spi_en   <= 1'b1;
                        byte_cnt_q <= '0;
                        byte_pos_q <= '0;
                        word_idx_q <= '0;
                    end
                end

                StArm: begin
                    if (drdy_fall) begin
                        state_q <= StReq;
                        O_rx_en <= 1'b1;
                    end
                end

                StReq: begin
                    state_q    <= StWait;
                    wait_cnt_q <= '0;
                end

                StWait: begin
                    if (I_rx_done) begin
                        word_sr_q <= {word_sr_q[7:0], I_rx_data};
                        if (byte_pos_q == 2'd2) begin
                            byte_pos_q <= '0;
                            word_idx_q <= word_idx_q + 1'b1;
                            if (word_idx_q == '0) begin
                                O_status       <= {word_sr_q, I_rx_data};
                                O_status_valid <= 1'b1;
                                O_sync_err     <= (word_sr_q[15:12] != STATUS_SYNC);
                            end else begin
                                O_ch_data    <= {word_sr_q, I_rx_data};
                                O_ch_idx     <= 3'(word_idx_q - 1'b1);
                                O_ch_valid   <= 1'b1;
                                O_frame_done <= (word_idx_q == IDX_W'(N_CH));
                            end
                        end else begin
                            byte_pos_q <= byte_pos_q + 1'b1;
                        end

                        if (byte_cnt_q == CNT_W'(FRAME_BYTES - 1)) begin
                            state_q <= StDone;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                            state_q    <= StReq;
                            O_rx_en    <= 1'b1;
                        end
                    end else if (wait_cnt_q == WAIT_W'(RX_TIMEOUT - 1)) begin
                        // Abandon the partial frame; nothing more is strobed for it.
                        O_timeout  <= 1'b1;
                        state_q    <= StArm;
                        byte_cnt_q <= '0;
                        byte_pos_q <= '0;
                        word_idx_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end

                StDone: begin
                    byte_cnt_q <= '0;
                    byte_pos_q <= '0;
                    word_idx_q <= '0;
                    if (I_enable) begin
                        state_q <= StArm;
                    end else begin
                        state_q  <= StIdle;
                        O_spi_en <= 1'b0;
                    end
                end

                default: begin
                    state_q  <= StIdle;
                    O_spi_en <= 1'b0;
                end
            endcase
        end
    end

    // A DRDY edge that cannot start a frame is recorded; set beats clear.
    always_ff @(posedge I_clk_50M or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_overrun <= 1'b0;
        end else if (drdy_fall && (state_q != StArm)) begin
            O_overrun <= 1'b1;
        end else if (I_clr_ovr) begin
            O_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ads131_frame_rx.sv
// Directed bench: byte-engine model, strobe monitor and hand-computed expectations.
module tb_ads131_frame_rx;

    logic        clk;
    logic        I_rst_n;
    logic        I_enable;
    logic        I_drdy_n;
    logic        O_spi_en;
    logic        O_rx_en;
    logic        I_rx_done;
    logic [7:0]  I_rx_data;
    logic [23:0] O_status;
    logic        O_status_valid;
    logic [23:0] O_ch_data;
    logic [2:0]  O_ch_idx;
    logic        O_ch_valid;
    logic        O_frame_done;
    logic        O_sync_err;
    logic        O_timeout;
    logic        O_overrun;
    logic        I_clr_ovr;

    ads131_frame_rx #(
        .N_CH       (8),
        .RX_TIMEOUT (1023)
    ) dut (
        .I_clk_50M      (clk),
        .I_rst_n        (I_rst_n),
        .I_enable       (I_enable),
        .I_drdy_n       (I_drdy_n),
        .O_spi_en       (O_spi_en),
        .O_rx_en        (O_rx_en),
        .I_rx_done      (I_rx_done),
        .I_rx_data      (I_rx_data),
        .O_status       (O_status),
        .O_status_valid (O_status_valid),
        .O_ch_data      (O_ch_data),
        .O_ch_idx       (O_ch_idx),
        .O_ch_valid     (O_ch_valid),
        .O_frame_done   (O_frame_done),
        .O_sync_err     (O_sync_err),
        .O_timeout      (O_timeout),
        .O_overrun      (O_overrun),
        .I_clr_ovr      (I_clr_ovr)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    logic [58:0] outs;
    assign outs = {O_spi_en, O_rx_en, O_status, O_status_valid, O_ch_data, O_ch_idx,
                   O_ch_valid, O_frame_done, O_sync_err, O_timeout, O_overrun};

    logic [23:0] chv [0:7] = '{24'h000001, 24'h000010, 24'h000100, 24'h001000,
                               24'h010000, 24'h100000, 24'h7FFFFF, 24'h800000};
    logic [7:0]  tx [0:26];
    logic [23:0] ch_seen [0:7];
    int          eng_idx;
    int          silent_lim;
    int          n_vec, n_err;
    int          cyc, n_rxen, n_stat, n_sync, n_err_v, n_ch, idx_bad, n_fd, n_fd_ok, n_to;
    int          last_rxen_cyc, to_cyc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_frame(input logic [7:0] st0);
        logic [23:0] w;
        for (int i = 0; i < 9; i++) begin
            w = (i == 0) ? {st0, 16'h0000} : chv[i-1];
            tx[3*i]   = w[23:16];
            tx[3*i+1] = w[15:8];
            tx[3*i+2] = w[7:0];
        end
    endtask

    task automatic clear_counts();
        n_rxen = 0; n_stat = 0; n_sync = 0; n_err_v = 0; n_ch = 0; idx_bad = 0;
        n_fd = 0; n_fd_ok = 0; n_to = 0;
        for (int i = 0; i < 8; i++) ch_seen[i] = 24'hxxxxxx;
    endtask

    task automatic drdy_pulse();
        @(posedge clk); #1 I_drdy_n = 1'b0;
        repeat (4) @(posedge clk);
        #1 I_drdy_n = 1'b1;
    endtask

    task automatic wait_frame(input string tag);
        int k;
        k = 0;
        while (n_fd == 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 64'(n_fd > 0), 64'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_bytes(input string tag, input int n);
        int k;
        k = 0;
        while (eng_idx < n && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq(tag, 64'(eng_idx >= n), 64'd1);
    endtask

    // Byte engine: answers each request with the next frame byte one cycle later.
    initial begin
        I_rx_done = 1'b0;
        I_rx_data = 8'h00;
        forever begin
            @(posedge clk); #1;
            I_rx_done = 1'b0;
            if (O_rx_en === 1'b1 && eng_idx < silent_lim && eng_idx < 27) begin
                @(posedge clk); #1;
                I_rx_data = tx[eng_idx];
                I_rx_done = 1'b1;
                eng_idx++;
            end
        end
    end

    initial begin
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (O_rx_en) begin n_rxen++; last_rxen_cyc = cyc; end
            if (O_status_valid) begin n_stat++; if (O_sync_err) n_err_v++; end
            if (O_sync_err) n_sync++;
            if (O_ch_valid) begin
                if (O_ch_idx != 3'(n_ch)) idx_bad++;
                ch_seen[O_ch_idx] = O_ch_data;
                n_ch++;
            end
            if (O_frame_done) begin n_fd++; if (O_ch_valid && O_ch_idx == 3'd7) n_fd_ok++; end
            if (O_timeout) begin n_to++; to_cyc = cyc; end
        end
    end

    initial begin
        n_vec = 0; n_err = 0;
        I_rst_n = 1'b1; I_enable = 1'b0; I_drdy_n = 1'b1; I_clr_ovr = 1'b0;
        eng_idx = 0; silent_lim = 27;
        clear_counts();
        load_frame(8'hC0);
        #3 I_rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_outputs", 64'(outs), 64'd0);
        @(posedge clk); #1 I_rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("idle_spi_en", 64'(O_spi_en), 64'd0);
        I_enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("arm_spi_en", 64'(O_spi_en), 64'd1);

        // Nominal frame.
        clear_counts(); eng_idx = 0;
        drdy_pulse();
        wait_frame("t1_frame_seen");
        check_eq("t1_rx_en_cnt", 64'(n_rxen), 64'd27);
        check_eq("t1_status", 64'(O_status), 64'hC00000);
        check_eq("t1_status_cnt", 64'(n_stat), 64'd1);
        check_eq("t1_sync_err", 64'(n_sync), 64'd0);
        check_eq("t1_ch_cnt", 64'(n_ch), 64'd8);
        check_eq("t1_ch_order", 64'(idx_bad), 64'd0);
        check_eq("t1_ch0", 64'(ch_seen[0]), 64'h000001);
        check_eq("t1_ch6", 64'(ch_seen[6]), 64'h7FFFFF);
        check_eq("t1_ch7", 64'(ch_seen[7]), 64'h800000);
        check_eq("t1_fd_idx7", 64'(n_fd_ok), 64'd1);
        check_eq("t1_ch_hold", 64'(O_ch_data), 64'h800000);
        check_eq("t1_overrun", 64'(O_overrun), 64'd0);

        // Bad status header.
        load_frame(8'h40);
        clear_counts(); eng_idx = 0;
        drdy_pulse();
        wait_frame("t2_frame_seen");
        check_eq("t2_status", 64'(O_status), 64'h400000);
        check_eq("t2_sync_err_cnt", 64'(n_sync), 64'd1);
        check_eq("t2_sync_with_valid", 64'(n_err_v), 64'd1);
        check_eq("t2_ch_cnt", 64'(n_ch), 64'd8);

        // Second DRDY mid-frame, with clear asserted across the edge.
        load_frame(8'hC0);
        clear_counts(); eng_idx = 0;
        drdy_pulse();
        wait_bytes("t3_reach_byte10", 10);
        @(posedge clk); #1 I_drdy_n = 1'b0;
        @(posedge clk); #1 I_clr_ovr = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 I_clr_ovr = 1'b0;
        check_eq("t3_set_beats_clr", 64'(O_overrun), 64'd1);
        repeat (3) @(posedge clk);
        #1 I_drdy_n = 1'b1;
        wait_frame("t3_frame_seen");
        check_eq("t3_ch_cnt", 64'(n_ch), 64'd8);
        check_eq("t3_rx_en_cnt", 64'(n_rxen), 64'd27);
        check_eq("t3_overrun_sticky", 64'(O_overrun), 64'd1);
        I_clr_ovr = 1'b1;
        @(posedge clk); #1 I_clr_ovr = 1'b0;
        check_eq("t3_overrun_clr", 64'(O_overrun), 64'd0);

        // Engine goes silent after five bytes.
        clear_counts(); eng_idx = 0; silent_lim = 5;
        drdy_pulse();
        begin
            int k;
            k = 0;
            while (n_to == 0 && k < 1500) begin
                @(negedge clk);
                k++;
            end
        end
        check_eq("t4_timeout_cnt", 64'(n_to), 64'd1);
        check_eq("t4_timeout_delay", 64'(to_cyc - last_rxen_cyc), 64'd1024);
        check_eq("t4_no_ch", 64'(n_ch), 64'd0);
        check_eq("t4_rx_en_cnt", 64'(n_rxen), 64'd6);
        repeat (5) @(posedge clk);
        #1;
        check_eq("t4_no_late_strobe", 64'(n_ch + n_fd), 64'd0);
        clear_counts(); eng_idx = 0; silent_lim = 27;
        drdy_pulse();
        wait_frame("t4_recover_seen");
        check_eq("t4_recover_ch_cnt", 64'(n_ch), 64'd8);
        check_eq("t4_recover_ch7", 64'(ch_seen[7]), 64'h800000);

        // Enable dropped mid-frame.
        clear_counts(); eng_idx = 0;
        drdy_pulse();
        wait_bytes("t5_reach_byte12", 12);
        I_enable = 1'b0;
        wait_frame("t5_frame_seen");
        check_eq("t5_ch_cnt", 64'(n_ch), 64'd8);
        check_eq("t5_spi_en_off", 64'(O_spi_en), 64'd0);

        // Reset mid-frame.
        I_enable = 1'b1;
        repeat (3) @(posedge clk);
        clear_counts(); eng_idx = 0;
        drdy_pulse();
        wait_bytes("t6_reach_byte12", 12);
        I_rst_n = 1'b0;
        #1;
        check_eq("t6_rst_outputs", 64'(outs), 64'd0);
        @(posedge clk); #1 I_rst_n = 1'b1;
        clear_counts();
        repeat (60) @(posedge clk);
        #1;
        check_eq("t6_no_strobes", 64'(n_stat + n_ch + n_rxen), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ads131_frame_rx.md
ADS131_FRAME_RX -- requirements
Module: ads131_frame_rx

Interface
- REQ-001: Parameters, each given as name, default, meaning:
  - N_CH, 8, channels per frame.
  - RX_TIMEOUT, 1023, maximum clock cycles to wait for one byte.
- REQ-002: I_clk_50M  in  1  system clock, 50 MHz.
- REQ-003: I_rst_n  in  1  asynchronous, active-low reset.
- REQ-004: I_enable  in  1  level; 1 = capture frames.
- REQ-005: I_drdy_n  in  1  ADC DRDY, asynchronous, active-low.
- REQ-006: O_spi_en  out  1  enable to the SPI byte engine.
- REQ-007: O_rx_en  out  1  one-cycle byte-read request.
- REQ-008: I_rx_done  in  1  one-cycle pulse; byte is valid on I_rx_data.
- REQ-009: I_rx_data  in  8  received byte.
- REQ-010: O_status  out  24  frame status word.
- REQ-011: O_status_valid  out  1  one-cycle strobe for O_status.
- REQ-012: O_ch_data  out  24  channel sample, two's complement.
- REQ-013: O_ch_idx  out  3  channel index, 0..N_CH-1.
- REQ-014: O_ch_valid  out  1  one-cycle strobe for O_ch_data/O_ch_idx.
- REQ-015: O_frame_done  out  1  one-cycle pulse at the end of a frame.
- REQ-016: O_sync_err  out  1  one-cycle pulse; status header mismatch.
- REQ-017: O_timeout  out  1  one-cycle pulse; byte wait aborted.
- REQ-018: O_overrun  out  1  sticky; DRDY arrived during a frame.
- REQ-019: I_clr_ovr  in  1  clears O_overrun.

Function
- REQ-020: I_drdy_n SHALL pass through a 2-flop synchronizer; a falling edge SHALL be detected on the synchronized signal.
- REQ-021: The FSM SHALL have states IDLE, ARM, REQ, WAIT, DONE.
  - IDLE→ARM when I_enable=1.
  - ARM→REQ on a DRDY edge.
  - REQ→WAIT always, after one cycle.
  - WAIT→REQ on I_rx_done when bytes remain.
  - WAIT→DONE on I_rx_done of the last byte.
  - DONE→ARM if I_enable=1, else DONE→IDLE.
- REQ-022: O_rx_en SHALL be 1 for exactly the one cycle spent in REQ, and at most one request SHALL be outstanding.
- REQ-023: Latency SHALL be 1 cycle from the synchronized DRDY edge cycle to O_rx_en=1.
- REQ-024: A frame SHALL be FRAME_BYTES = 3*(N_CH+1) bytes, MSB first.
  - Word 0 is the status word.
  - Words 1..N_CH are channels 0..N_CH-1.
- REQ-025: Each completed 24-bit word SHALL be presented on the registered outputs, with its strobe high for one cycle, in the cycle after the I_rx_done of its third byte.
- REQ-026: O_frame_done SHALL be asserted in the same cycle as O_ch_valid with O_ch_idx=N_CH-1.
- REQ-027: O_sync_err SHALL pulse together with O_status_valid when O_status[23:20] != 4'hC.
- REQ-028: O_status and O_ch_data SHALL hold their last value between strobes.
- REQ-029: A DRDY edge outside ARM SHALL set O_overrun; the current frame SHALL continue and that edge SHALL NOT start a frame.
- REQ-030: I_clr_ovr SHALL clear O_overrun; if set and clear occur in the same cycle, set SHALL win.
- REQ-031: A byte timeout SHALL be handled as follows:
  - The wait counter SHALL reset on entry to WAIT.
  - If the count reaches RX_TIMEOUT without I_rx_done, O_timeout SHALL pulse, the partial frame SHALL be discarded (no further strobes) and the FSM SHALL go to ARM.
- REQ-032: I_rx_done outside WAIT SHALL be ignored.
- REQ-033: I_enable deasserted mid-frame SHALL NOT abort the frame; it SHALL complete, then the FSM SHALL go to IDLE.
- REQ-034: O_spi_en SHALL be 1 whenever the state is not IDLE.
- REQ-035: The byte counter SHALL count 0..FRAME_BYTES-1 and SHALL clear on entry to ARM.

Reset
- REQ-036: On I_rst_n=0 the block SHALL asynchronously enter IDLE.
- REQ-037: On reset all outputs, counters and synchronizer flops SHALL go to 0, except the synchronizer flops, which SHALL go to 1 (DRDY inactive).
- REQ-038: Reset asserted mid-frame SHALL discard the frame, and no strobe SHALL follow reset release until a new DRDY edge.

Structure
- REQ-039: Package ads131_pkg SHALL hold the following:
  - the state encoding;
  - N_CH default;
  - BYTES_PER_WORD=3;
  - the FRAME_BYTES function;
  - STATUS_SYNC=4'hC.
- REQ-040: Sub-module ads131_drdy_sync SHALL contain the synchronizer and the falling-edge detector, with a one-cycle edge output.

Verification
- REQ-041: Enable, one DRDY low, byte engine returning bytes C0 00 00, then 00 00 01 ... 80 00 00 → O_status=C00000 with no sync_err, ch0=000001, ch7=800000, frame_done with idx 7, exactly 27 O_rx_en pulses.
- REQ-042: First status byte 0x40 → O_sync_err pulses with O_status_valid; channel strobes still occur.
- REQ-043: Second DRDY edge after byte 10 → O_overrun=1, frame completes normally; I_clr_ovr in the same cycle as the edge → O_overrun=1.
- REQ-044: Byte engine silent after byte 5 → O_timeout after 1023 cycles, no channel strobes, next DRDY captures a full frame.
- REQ-045: Deassert I_enable at byte 12 → all 8 channels are emitted, then IDLE with O_spi_en=0; assert I_rst_n=0 at byte 12 → all outputs are 0 immediately.
